// File: rtl/larpix_piso_rx.sv
// UART receiver for one LArPix_v3 piso line: start bit, WIDTH data bits LSB first, stop bit.
// Delivers packets under valid/ready with odd-parity and framing checks plus saturating counters.
module larpix_piso_rx #(
    parameter int WIDTH       = 64,
    parameter int CLK_PER_BIT = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             rx_in,
    input  logic             packet_ready,
    input  logic             clear_counts,
    output logic [WIDTH-1:0] packet_out,
    output logic             packet_valid,
    output logic             parity_err,
    output logic             framing_err,
    output logic             overflow,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int HALF = CLK_PER_BIT / 2;
    localparam int PW   = $clog2(CLK_PER_BIT + 1);
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [PW-1:0]     phase_q, phase_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              armed_q, armed_d;
    logic [WIDTH-1:0]  packet_out_q, packet_out_d;
    logic              packet_valid_q, packet_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              framing_err_q, framing_err_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              pkt_inc, err_inc, parity_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            state_q        <= IDLE;
            phase_q        <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            armed_q        <= 1'b0;
            packet_out_q   <= '0;
            packet_valid_q <= 1'b0;
            parity_err_q   <= 1'b0;
            framing_err_q  <= 1'b0;
            overflow_q     <= 1'b0;
            pkt_count_q    <= '0;
            err_count_q    <= '0;
        end else begin
            rx_meta_q      <= rx_in;
            rx_s_q         <= rx_meta_q;
            state_q        <= state_d;
            phase_q        <= phase_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            armed_q        <= armed_d;
            packet_out_q   <= packet_out_d;
            packet_valid_q <= packet_valid_d;
            parity_err_q   <= parity_err_d;
            framing_err_q  <= framing_err_d;
            overflow_q     <= overflow_d;
            pkt_count_q    <= pkt_count_d;
            err_count_q    <= err_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        armed_d        = armed_q | rx_s_q;
        packet_out_d   = packet_out_q;
        packet_valid_d = packet_valid_q;
        parity_err_d   = parity_err_q;
        framing_err_d  = 1'b0;
        overflow_d     = 1'b0;
        pkt_inc        = 1'b0;
        err_inc        = 1'b0;
        parity_ok      = ^shift_q;

        if (packet_valid_q && packet_ready) begin
            packet_valid_d = 1'b0;
        end

        // armed_q blocks a start while the line is still low after enable returns;
        // a new frame needs a genuine high-to-low transition.
        if (!enable) begin
            state_d = IDLE;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (armed_q && !rx_s_q) begin
                        state_d = START;
                        phase_d = PW'(1);
                    end
                end
                START: begin
                    if (phase_q == PW'(HALF)) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            phase_d = PW'(1);
                            bit_d   = '0;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                DATA: begin
                    if (phase_q == PW'(CLK_PER_BIT)) begin
                        shift_d = {rx_s_q, shift_q[WIDTH-1:1]};
                        phase_d = PW'(1);
                        if (bit_q == BW'(WIDTH - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                STOP: begin
                    if (phase_q == PW'(CLK_PER_BIT)) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                            if (!packet_valid_q || packet_ready) begin
                                packet_out_d   = shift_q;
                                packet_valid_d = 1'b1;
                                parity_err_d   = ~parity_ok;
                                pkt_inc        = 1'b1;
                                err_inc        = ~parity_ok;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else begin
                            state_d       = WAIT_HIGH;
                            framing_err_d = 1'b1;
                            err_inc       = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        if (clear_counts) begin
            pkt_count_d = '0;
            err_count_d = '0;
        end else begin
            if (pkt_inc && !(&pkt_count_q)) pkt_count_d = pkt_count_q + CNT_W'(1);
            if (err_inc && !(&err_count_q)) err_count_d = err_count_q + CNT_W'(1);
        end
    end

    assign packet_out   = packet_out_q;
    assign packet_valid = packet_valid_q;
    assign parity_err   = parity_err_q;
    assign framing_err  = framing_err_q;
    assign overflow     = overflow_q;
    assign pkt_count    = pkt_count_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_larpix_piso_rx.sv
// Directed bench for larpix_piso_rx: latency, parity, framing, overflow, glitch, reset, enable, saturation.
module tb_larpix_piso_rx;

    localparam int CPB = 4;
    localparam int W   = 64;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic          rx_in = 1'b1;
    logic          packet_ready = 1'b0;
    logic          clear_counts = 1'b0;
    logic [W-1:0]  packet_out;
    logic          packet_valid;
    logic          parity_err;
    logic          framing_err;
    logic          overflow;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_n    = 0;
    int ov_n    = 0;

    larpix_piso_rx #(
        .WIDTH(W),
        .CLK_PER_BIT(CPB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .rx_in(rx_in),
        .packet_ready(packet_ready),
        .clear_counts(clear_counts),
        .packet_out(packet_out),
        .packet_valid(packet_valid),
        .parity_err(parity_err),
        .framing_err(framing_err),
        .overflow(overflow),
        .pkt_count(pkt_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_err) fe_n++;
        if (overflow) ov_n++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit (264 cycles later).
    task automatic send_frame(input logic [W-1:0] d, input logic stop);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic consume();
        packet_ready = 1'b1;
        @(negedge clk);
        packet_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_cnt();
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [W-1:0] P_EVEN2 = 64'h8000_0000_0000_0001;
    localparam logic [W-1:0] P_A     = 64'h0123_4567_89AB_CDEF;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pv",   packet_valid, 0);
        check("rst_out",  packet_out, 0);
        check("rst_perr", parity_err, 0);
        check("rst_fe",   framing_err, 0);
        check("rst_ov",   overflow, 0);
        check("rst_pkt",  pkt_count, 0);
        check("rst_err",  err_count, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // clean frame, even parity, exact latency
        send_frame(P_EVEN2, 1'b1);
        check("t1_pv_early", packet_valid, 0);
        @(negedge clk);
        check("t1_pv",   packet_valid, 1);
        check("t1_out",  packet_out, 64'h8000_0000_0000_0001);
        check("t1_perr", parity_err, 1);
        check("t1_pkt",  pkt_count, 1);
        check("t1_err",  err_count, 1);
        consume();
        check("t1_pv_clr", packet_valid, 0);
        clear_cnt();
        check("clr_pkt", pkt_count, 0);
        check("clr_err", err_count, 0);

        // odd parity, ready held high: valid for exactly one cycle
        packet_ready = 1'b1;
        send_frame(64'h1, 1'b1);
        check("t2_pv_early", packet_valid, 0);
        @(negedge clk);
        check("t2_pv",   packet_valid, 1);
        check("t2_out",  packet_out, 64'h1);
        check("t2_perr", parity_err, 0);
        check("t2_pkt",  pkt_count, 1);
        check("t2_err",  err_count, 0);
        @(negedge clk);
        check("t2_pv_1cyc", packet_valid, 0);
        packet_ready = 1'b0;

        // framing error, line held low 20 cycles, then recovery
        clear_cnt();
        send_frame(64'hFFFF_0000_0000_0000, 1'b0);
        check("t3_fe_early", framing_err, 0);
        @(negedge clk);
        check("t3_fe",  framing_err, 1);
        check("t3_err", err_count, 1);
        check("t3_pv",  packet_valid, 0);
        @(negedge clk);
        check("t3_fe_pulse", framing_err, 0);
        repeat (18) @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_fe_count", fe_n, 1);
        check("t3_pv_none",  packet_valid, 0);
        send_frame(64'h7, 1'b1);
        @(negedge clk);
        check("t3b_pv",   packet_valid, 1);
        check("t3b_out",  packet_out, 64'h7);
        check("t3b_perr", parity_err, 0);
        check("t3b_pkt",  pkt_count, 1);
        check("t3b_err",  err_count, 1);
        consume();

        // back-to-back frames with ready low: second dropped
        clear_cnt();
        send_frame(P_A, 1'b1);
        send_frame(64'h7, 1'b1);
        check("t4_ov_early", overflow, 0);
        @(negedge clk);
        check("t4_ov", overflow, 1);
        @(negedge clk);
        check("t4_ov_pulse", overflow, 0);
        check("t4_pv",   packet_valid, 1);
        check("t4_out",  packet_out, 64'h0123_4567_89AB_CDEF);
        check("t4_perr", parity_err, 1);
        check("t4_pkt",  pkt_count, 1);
        check("t4_err",  err_count, 1);

        // one-cycle glitch while idle
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_pv",    packet_valid, 1);
        check("t5_out",   packet_out, 64'h0123_4567_89AB_CDEF);
        check("t5_pkt",   pkt_count, 1);
        check("t5_err",   err_count, 1);
        check("t5_fe_n",  fe_n, 1);
        check("t5_ov_n",  ov_n, 1);

        // reset in the middle of DATA
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_in = i[0];
            repeat (CPB) @(negedge clk);
        end
        reset_n = 1'b0;
        rx_in = 1'b1;
        @(negedge clk);
        check("t6_pv",   packet_valid, 0);
        check("t6_out",  packet_out, 0);
        check("t6_perr", parity_err, 0);
        check("t6_pkt",  pkt_count, 0);
        check("t6_err",  err_count, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(64'h7, 1'b1);
        @(negedge clk);
        check("t6b_pv",  packet_valid, 1);
        check("t6b_out", packet_out, 64'h7);
        check("t6b_pkt", pkt_count, 1);
        consume();

        // clear coinciding with increments
        send_frame(P_EVEN2, 1'b1);
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        check("t7_pv",   packet_valid, 1);
        check("t7_perr", parity_err, 1);
        check("t7_pkt",  pkt_count, 0);
        check("t7_err",  err_count, 0);
        consume();

        // enable dropped mid-frame
        fork
            send_frame(P_EVEN2, 1'b1);
            begin
                repeat (100) @(negedge clk);
                enable = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("t8_pv",   packet_valid, 0);
        check("t8_fe_n", fe_n, 1);
        check("t8_pkt",  pkt_count, 0);
        check("t8_err",  err_count, 0);
        send_frame(64'h7, 1'b1);
        @(negedge clk);
        check("t8b_pv",  packet_valid, 1);
        check("t8b_out", packet_out, 64'h7);
        check("t8b_pkt", pkt_count, 1);
        check("t8b_err", err_count, 0);
        consume();

        // counter saturation at 4'hF
        clear_cnt();
        packet_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            send_frame(P_EVEN2, 1'b1);
            @(negedge clk);
            if (k == 14) begin
                check("t9_pkt14", pkt_count, 14);
                check("t9_err14", err_count, 14);
            end
            if (k >= 15) begin
                check("t9_pkt_sat", pkt_count, 15);
                check("t9_err_sat", err_count, 15);
            end
        end
        packet_ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/larpix_piso_rx.md
Name: larpix_piso_rx

Overview:
- Primary-side (FPGA/test-controller) UART receiver that deserializes one LArPix_v3 piso output line into 64-bit packets.
- Sits between the chip's piso pin and the controller packet logic, or in the full-chip testbench as the packet checker.
- Frame format: start bit (0), 64 data bits LSB first, stop bit (1). Line idles high.
- Checks odd parity over all 64 bits and stop-bit framing, holds one received packet under a valid/ready handshake, and keeps saturating packet and error counters.

Parameters:
- WIDTH, 64: data bits per frame, start and stop bits excluded.
- CLK_PER_BIT, 4: clk cycles per UART bit. Must be even and >= 4.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  master clock.
- reset_n  input  1  asynchronous reset, active low.
- enable  input  1  high to receive; low aborts any frame in progress and holds the receiver in IDLE.
- rx_in  input  1  serial line from chip piso[n]; asynchronous to clk.
- packet_ready  input  1  downstream accepts packet_out.
- clear_counts  input  1  synchronous clear of both counters.
- packet_out  output  WIDTH  received packet.
- packet_valid  output  1  packet_out holds an unconsumed packet.
- parity_err  output  1  qualifies packet_out: parity of held packet was even.
- framing_err  output  1  one-cycle pulse: stop bit sampled 0.
- overflow  output  1  one-cycle pulse: good frame dropped because holding register was full.
- pkt_count  output  CNT_W  frames delivered, saturating.
- err_count  output  CNT_W  parity plus framing errors, saturating.

Behaviour:
- Reset: all outputs 0; synchronizer flops = 1; state = IDLE.
- Sync: rx_in passes through a 2-FF synchronizer (rx_s). All decisions use rx_s.
- Timing origin: the cycle rx_s is first 0 in IDLE is cycle 0. Let HALF = CLK_PER_BIT/2.
- IDLE: on rx_s == 0, go to START and clear the bit-phase counter.
- START: sample at cycle HALF.
  - rx_s == 1: glitch, go back to IDLE with no flags set.
  - rx_s == 0: go to DATA.
- DATA: data bit k (k = 0..WIDTH-1) is sampled at cycle HALF+(k+1)*CLK_PER_BIT and shifted in LSB first. After bit WIDTH-1, go to STOP.
- STOP: sample at cycle HALF+(WIDTH+1)*CLK_PER_BIT.
  - rx_s == 1: good frame, go to IDLE.
  - rx_s == 0: framing_err pulses the next cycle, err_count increments, data is discarded, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE.
- Parity: parity_ok = XOR of all WIDTH bits == 1 (odd).
- Good-frame delivery, on the cycle after the stop sample:
  - Holding register empty or being consumed this cycle: load packet_out; packet_valid=1; parity_err=~parity_ok; pkt_count increments. Packets with bad parity are delivered, and err_count also increments.
  - packet_valid=1 and packet_ready=0: new frame dropped; overflow pulses 1 cycle; the old packet is unchanged; no counter changes.
- Handshake: transfer occurs when packet_valid & packet_ready. packet_valid clears the next cycle unless a new load coincides, in which case the load wins and packet_valid stays 1. packet_out and parity_err are stable while packet_valid=1.
- Counters: saturate at all-ones and never wrap. If clear_counts coincides with an increment, clear wins.
- enable low: state goes to IDLE next cycle and the partial frame is discarded with no flags or counts. packet_valid, packet_out and counters are unaffected. Receiving resumes on the next falling edge after enable returns high.
- Reset mid-frame: immediate return to reset state and the frame is lost.
- Back-to-back frames: a start bit directly following a stop bit must be received. IDLE is reachable within the stop-bit period.

Test Plan:
- Clean frame, CLK_PER_BIT=4, packet 0x8000_0000_0000_0001 (two 1s, even parity) → packet_valid at cycle 2+2+65*4+1 after the rx_in start edge; packet_out=0x8000000000000001; parity_err=1; pkt_count=1; err_count=1.
- Frame 0x0000_0000_0000_0001 with packet_ready=1 → parity_err=0; packet_valid high exactly 1 cycle; pkt_count=1; err_count=0.
- Frame with stop bit forced 0, then line held low 20 cycles → no packet_valid; framing_err one pulse; err_count=1; next clean frame received correctly.
- Two back-to-back clean frames, packet_ready=0 → first packet held; overflow one pulse at the second frame's end; pkt_count=1; packet_out = first packet.
- 1-cycle low glitch on rx_in while idle → no state beyond START; no flags or counts. Reset asserted mid-DATA, then released → all outputs 0 and the next frame decodes correctly.
- Force pkt_count to 0xFFFF via 65535 frames, or use CNT_W=4 with 16 frames → counter holds at all-ones. clear_counts together with an increment → counters read 0.
